// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives PS/2 clock/data open-drain via pull-low enables; one byte per request.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERROR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

  state_t          state;
  logic [7:0]      data_q;
  logic            parity_q;
  logic [IW-1:0]   inh_cnt;
  logic [TW-1:0]   tout_cnt;
  logic [3:0]      n;
  logic            clk_meta, clk_sync, clk_prev;
  logic            data_meta, data_sync;
  logic            fe;

  // Idle bus level is high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= PS2_CLK_IN;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= PS2_DATA_IN;
      data_sync <= data_meta;
    end
  end

  assign fe = clk_prev & ~clk_sync;

  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      state       <= IDLE;
      data_q      <= '0;
      parity_q    <= 1'b0;
      inh_cnt     <= '0;
      tout_cnt    <= '0;
      n           <= '0;
      PS2_CLK_OE  <= 1'b0;
      PS2_DATA_OE <= 1'b0;
      TX_READY    <= 1'b1;
      TX_DONE     <= 1'b0;
      TX_ERROR    <= 1'b0;
    end else begin
      TX_DONE  <= 1'b0;
      TX_ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (TX_VALID) begin
            data_q     <= TX_DATA;
            parity_q   <= ~^TX_DATA;
            PS2_CLK_OE <= 1'b1;
            TX_READY   <= 1'b0;
            inh_cnt    <= '0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            PS2_DATA_OE <= 1'b1;
            state       <= REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        REQ: begin
          PS2_CLK_OE <= 1'b0;
          n          <= '0;
          tout_cnt   <= '0;
          state      <= SEND;
        end
        SEND: begin
          if (fe) begin
            tout_cnt <= '0;
            if (n != 4'hF) n <= n + 1'b1;
            // n still holds the pre-edge count, so it indexes the bit for this edge.
            case (n)
              4'd0, 4'd1, 4'd2, 4'd3,
              4'd4, 4'd5, 4'd6, 4'd7: PS2_DATA_OE <= ~data_q[n[2:0]];
              4'd8:  PS2_DATA_OE <= ~parity_q;
              4'd9:  PS2_DATA_OE <= 1'b0;
              4'd10: begin
                if (data_sync) begin
                  TX_ERROR <= 1'b1;
                  TX_READY <= 1'b1;
                  state    <= IDLE;
                end else begin
                  state <= WAIT_IDLE;
                end
              end
              default: ;
            endcase
          end else if (tout_cnt == TOUT_LAST) begin
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            TX_ERROR    <= 1'b1;
            TX_READY    <= 1'b1;
            state       <= IDLE;
          end else if (tout_cnt != TOUT_MAX) begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            TX_DONE  <= 1'b1;
            TX_READY <= 1'b1;
            state    <= IDLE;
          end else if (fe) begin
            tout_cnt <= '0;
          end else if (tout_cnt == TOUT_LAST) begin
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            TX_ERROR    <= 1'b1;
            TX_READY    <= 1'b1;
            state       <= IDLE;
          end else if (tout_cnt != TOUT_MAX) begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        default: begin
          PS2_CLK_OE  <= 1'b0;
          PS2_DATA_OE <= 1'b0;
          TX_READY    <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - bench for ps2_host_tx with a simple PS/2 device model
module tb_ps2_host_tx;

  localparam int H    = 50;    // device clock half period in system cycles
  localparam int TOUT = 1000;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLK_OE, DATA_OE;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY, TX_DONE, TX_ERROR;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  assign ps2_clk  = dev_clk & ~CLK_OE;
  assign ps2_data = dev_data & ~DATA_OE;

  ps2_host_tx #(.INHIBIT_CYCLES(2500), .TIMEOUT_CYCLES(TOUT)) dut (
    .CLK_25MHZ(clk), .RESET_N(RESET_N),
    .PS2_CLK_IN(ps2_clk), .PS2_DATA_IN(ps2_data),
    .PS2_CLK_OE(CLK_OE), .PS2_DATA_OE(DATA_OE),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .TX_DONE(TX_DONE), .TX_ERROR(TX_ERROR)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0;
  int oe_run = 0, last_oe_run = 0, rdy_run = 0, last_rdy_run = 0;

  always @(negedge clk) begin
    if (TX_DONE === 1'b1) done_cnt++;
    if (TX_ERROR === 1'b1) err_cnt++;
    if (CLK_OE === 1'b1) oe_run++;
    else if (oe_run != 0) begin last_oe_run = oe_run; oe_run = 0; end
    if (TX_READY === 1'b1) rdy_run++;
    else if (rdy_run != 0) begin last_rdy_run = rdy_run; rdy_run = 0; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device side: waits for the request, clocks nfe edges, samples on rising edges, acks on request.
  task automatic device_rx(input int nfe, input bit ack, output logic [9:0] bits);
    int t = 0;
    bits = '0;
    while (CLK_OE !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    chk("req_seen", (t < 4000), 1);
    chk("start_bit", DATA_OE, 1'b1);
    for (int i = 1; i <= nfe; i++) begin
      repeat (H) @(posedge clk);
      #1 dev_clk = 1'b0;
      if (i == nfe && nfe < 11) return;
      repeat (H) @(posedge clk);
      #1;
      if (i <= 10) bits[i-1] = ps2_data;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_data = 1'b0;
    end
    repeat (H) @(posedge clk);
    #1 dev_data = 1'b1;
  endtask

  task automatic wait_end(input int base);
    int t = 0;
    while (done_cnt + err_cnt == base && t < 400) begin @(negedge clk); t++; end
    chk("end_seen", (t < 400), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_oe_high();
    int t = 0;
    while (CLK_OE !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("oe_rise", (t < 20), 1);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input bit ack,
                           input logic [9:0] exp_bits, input int exp_done, input int exp_err);
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1 TX_VALID = 1'b1; TX_DATA = d;
    @(posedge clk); #1 TX_VALID = 1'b0; TX_DATA = 8'h00;
    device_rx(11, ack, bits);
    wait_end(d0 + e0);
    chk({name, "_oe_len"}, last_oe_run, 2501);
    chk({name, "_bits"}, bits, exp_bits);
    chk({name, "_done"}, done_cnt - d0, exp_done);
    chk({name, "_err"}, err_cnt - e0, exp_err);
    chk({name, "_clk_rel"}, CLK_OE, 1'b0);
    chk({name, "_dat_rel"}, DATA_OE, 1'b0);
    chk({name, "_ready"}, TX_READY, 1'b1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         ack;
    logic [9:0] bits;   // {stop, parity, data} in send order from bit 0
    int         done_d;
    int         err_d;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [9:0] b1, b2;
    int cyc;
    vecs[0] = '{"ed",    8'hED, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{"x01",   8'h01, 1'b1, 10'h201, 1, 0};
    vecs[2] = '{"x00",   8'h00, 1'b1, 10'h300, 1, 0};
    vecs[3] = '{"noack", 8'hA5, 1'b0, 10'h3A5, 0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_oe", CLK_OE, 1'b0);
    chk("rst_data_oe", DATA_OE, 1'b0);
    chk("rst_ready", TX_READY, 1'b1);
    chk("rst_pulses", {TX_DONE, TX_ERROR}, 2'b00);
    @(posedge clk); #1 RESET_N = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].name, vecs[i].data, vecs[i].ack, vecs[i].bits, vecs[i].done_d, vecs[i].err_d);

    // Device never clocks: error lands TOUT cycles after SEND entry.
    @(posedge clk); #1 TX_VALID = 1'b1; TX_DATA = 8'h55;
    @(posedge clk); #1 TX_VALID = 1'b0;
    cyc = 0;
    while (CLK_OE !== 1'b0 && cyc < 4000) begin @(negedge clk); cyc++; end
    chk("tout_send", (cyc < 4000), 1);
    cyc = 0;
    while (TX_ERROR !== 1'b1 && cyc < 1200) begin @(negedge clk); cyc++; end
    chk("tout_cycles", cyc, TOUT);
    chk("tout_dat_rel", DATA_OE, 1'b0);
    chk("tout_ready", TX_READY, 1'b1);
    repeat (5) @(posedge clk);

    // Reset after the 5th falling edge; bit 4 of 0x0F is 0 so data is being pulled low.
    @(posedge clk); #1 TX_VALID = 1'b1; TX_DATA = 8'h0F;
    @(posedge clk); #1 TX_VALID = 1'b0;
    device_rx(5, 1'b1, b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_dat", DATA_OE, 1'b1);
    @(posedge clk); #1 RESET_N = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_clk_oe", CLK_OE, 1'b0);
    chk("abort_dat_oe", DATA_OE, 1'b0);
    chk("abort_ready", TX_READY, 1'b1);
    @(posedge clk); #1 RESET_N = 1'b1; dev_clk = 1'b1;
    repeat (5) @(posedge clk);
    run_frame("xff", 8'hFF, 1'b1, 10'h3FF, 1, 0);

    // Back-to-back frames with TX_VALID held; data change during frame 1 is for frame 2.
    cyc = done_cnt;
    @(posedge clk); #1 TX_VALID = 1'b1; TX_DATA = 8'hF4;
    @(posedge clk); #1 TX_DATA = 8'hED;
    device_rx(11, 1'b1, b1);
    wait_oe_high();
    @(posedge clk); #1 TX_VALID = 1'b0;
    chk("b2b_ready_gap", last_rdy_run, 1);
    device_rx(11, 1'b1, b2);
    wait_end(cyc + err_cnt);
    chk("b2b_bits1", b1, 10'h2F4);
    chk("b2b_bits2", b2, 10'h3ED);
    chk("b2b_done", done_cnt - cyc, 2);
    chk("b2b_ready", TX_READY, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
